// File: rtl/isp_awb_pkg.sv
// Shared types and constants for the gray-world auto-white-balance stage.
package isp_awb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      DIV_R,
      DIV_B,
      UPDATE
   } awb_state_t;

   function automatic int unsigned GAIN_UNITY(input int unsigned gain_frac);
      return 32'd1 << gain_frac;
   endfunction

endpackage

// File: rtl/isp_awb_div.sv
// Serial restoring divider: quotient = min(dividend*2^GAIN_FRAC / divisor, all-ones),
// one quotient bit per cycle, GAIN_W cycles starting with the start cycle.
module isp_awb_div
   import isp_awb_pkg::*;
#(
   parameter int SUM_W     = 32,
   parameter int GAIN_W    = 12,
   parameter int GAIN_FRAC = 8
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SUM_W-1:0]  dividend,
   input  logic [SUM_W-1:0]  divisor,
   output logic              done,
   output logic              zero,
   output logic [GAIN_W-1:0] quotient
);

   localparam int SH    = GAIN_W - GAIN_FRAC;
   localparam int CNT_W = $clog2(GAIN_W);

   logic [SUM_W-1:0]  rem, rem_cur, rem_init, rem_nxt;
   logic [GAIN_W-1:0] lo, lo_cur, lo_init;
   logic [GAIN_W-1:0] q, q_cur;
   logic [SUM_W:0]    trial;
   logic              ge, ovf, ovf_chk, active;
   logic [CNT_W-1:0]  cnt;

   // The start cycle already produces the MSB, so the operands feed the step directly.
   always_comb begin
      rem_init = dividend >> SH;
      lo_init  = GAIN_W'({dividend, GAIN_FRAC'(0)});
      ovf_chk  = {SH'(0), dividend} >= {divisor, SH'(0)};
      rem_cur  = start ? rem_init : rem;
      lo_cur   = start ? lo_init  : lo;
      q_cur    = start ? '0       : q;
      trial    = {rem_cur, lo_cur[GAIN_W-1]};
      ge       = trial >= {1'b0, divisor};
      rem_nxt  = ge ? SUM_W'(trial - {1'b0, divisor}) : trial[SUM_W-1:0];
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         rem    <= '0;
         lo     <= '0;
         q      <= '0;
         cnt    <= '0;
         active <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start || active) begin
            rem <= rem_nxt;
            lo  <= lo_cur << 1;
            q   <= {q_cur[GAIN_W-2:0], ge};
         end
         if (start) begin
            ovf    <= ovf_chk;
            zero   <= (divisor == '0);
            cnt    <= CNT_W'(GAIN_W - 1);
            active <= 1'b1;
         end else if (active) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

   assign quotient = ovf ? '1 : q;

endmodule

// File: rtl/isp_awb.sv
// Gray-world AWB: per-frame R/G/B statistics, gain computation in vertical blank,
// and a 2-cycle gain-apply pipeline on the RGB stream.
module isp_awb
   import isp_awb_pkg::*;
#(
   parameter int BITS      = 8,
   parameter int SUM_W     = 32,
   parameter int GAIN_W    = 12,
   parameter int GAIN_FRAC = 8
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              awb_en,
   input  logic              in_href,
   input  logic              in_vsync,
   input  logic              in_de,
   input  logic [BITS-1:0]   in_r,
   input  logic [BITS-1:0]   in_g,
   input  logic [BITS-1:0]   in_b,
   output logic              out_href,
   output logic              out_vsync,
   output logic              out_de,
   output logic [BITS-1:0]   out_r,
   output logic [BITS-1:0]   out_g,
   output logic [BITS-1:0]   out_b,
   output logic [GAIN_W-1:0] gain_r,
   output logic [GAIN_W-1:0] gain_b,
   output logic              busy
);

   localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(GAIN_UNITY(GAIN_FRAC));
   localparam int P_W   = BITS + GAIN_W;
   localparam int CNT_W = $clog2(GAIN_W);

   awb_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic              vs_d, vs_rise, latch;

   logic [BITS-1:0]   pix     [3];
   logic [SUM_W-1:0]  acc     [3];
   logic [SUM_W:0]    acc_sum [3];
   logic [SUM_W-1:0]  acc_sat [3];
   logic [SUM_W-1:0]  opnd    [3];

   logic              div_start, div_done, div_zero;
   logic [GAIN_W-1:0] div_q;
   logic [GAIN_W-1:0] pend_r, pend_b, nxt_r, nxt_b, q_r_hold;
   logic              zero_r_hold, commit;

   logic [GAIN_W-1:0] gsel [3];
   logic [P_W-1:0]    prod [3];
   logic [BITS-1:0]   opx  [3];
   logic              h1, v1, d1;

   assign pix[0]  = in_r;
   assign pix[1]  = in_g;
   assign pix[2]  = in_b;
   assign vs_rise = in_vsync & ~vs_d;
   assign latch   = (state == IDLE) && vs_rise;

   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         acc_sum[i] = {1'b0, acc[i]} + (SUM_W+1)'(pix[i]);
         acc_sat[i] = acc_sum[i][SUM_W] ? '1 : acc_sum[i][SUM_W-1:0];
      end
   end

   // A pixel coinciding with the latch already belongs to the new frame.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d <= 1'b0;
         for (int unsigned i = 0; i < 3; i++) begin
            acc[i]  <= '0;
            opnd[i] <= '0;
         end
      end else begin
         vs_d <= in_vsync;
         for (int unsigned i = 0; i < 3; i++) begin
            if (latch) begin
               opnd[i] <= acc[i];
               acc[i]  <= in_href ? SUM_W'(pix[i]) : '0;
            end else if (in_href) begin
               acc[i] <= acc_sat[i];
            end
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (vs_rise) begin
               state <= LATCH;
               busy  <= 1'b1;
            end
            LATCH: begin
               state <= DIV_R;
               cnt   <= '0;
            end
            DIV_R: if (cnt == CNT_W'(GAIN_W - 1)) begin
               state <= DIV_B;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DIV_B: if (cnt == CNT_W'(GAIN_W - 1)) begin
               state <= UPDATE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            UPDATE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign div_start = ((state == DIV_R) || (state == DIV_B)) && (cnt == '0);

   isp_awb_div #(
      .SUM_W     (SUM_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
   ) u_div (
      .pclk     (pclk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (opnd[1]),
      .divisor  ((state == DIV_B) ? opnd[2] : opnd[0]),
      .done     (div_done),
      .zero     (div_zero),
      .quotient (div_q)
   );

   assign nxt_r = zero_r_hold ? pend_r : q_r_hold;
   assign nxt_b = div_zero    ? pend_b : div_q;

   // Active gains only change on a blanking cycle so no line mixes two gains.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r      <= UNITY;
         pend_b      <= UNITY;
         gain_r      <= UNITY;
         gain_b      <= UNITY;
         q_r_hold    <= '0;
         zero_r_hold <= 1'b0;
         commit      <= 1'b0;
      end else begin
         if ((state == DIV_B) && div_done) begin
            q_r_hold    <= div_q;
            zero_r_hold <= div_zero;
         end
         if (state == UPDATE) begin
            pend_r <= nxt_r;
            pend_b <= nxt_b;
            if (!in_href) begin
               gain_r <= nxt_r;
               gain_b <= nxt_b;
               commit <= 1'b0;
            end else begin
               commit <= 1'b1;
            end
         end else if (commit && !in_href) begin
            gain_r <= pend_r;
            gain_b <= pend_b;
            commit <= 1'b0;
         end
      end
   end

   function automatic logic [BITS-1:0] sat_px(input logic [P_W-1:0] p);
      logic [P_W-1:0] s;
      s = p >> GAIN_FRAC;
      return (s[P_W-1:BITS] != '0) ? '1 : s[BITS-1:0];
   endfunction

   assign gsel[0] = awb_en ? gain_r : UNITY;
   assign gsel[1] = UNITY;
   assign gsel[2] = awb_en ? gain_b : UNITY;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         h1        <= 1'b0;
         v1        <= 1'b0;
         d1        <= 1'b0;
         out_href  <= 1'b0;
         out_vsync <= 1'b0;
         out_de    <= 1'b0;
         for (int unsigned i = 0; i < 3; i++) begin
            prod[i] <= '0;
            opx[i]  <= '0;
         end
      end else begin
         h1        <= in_href;
         v1        <= in_vsync;
         d1        <= in_de;
         out_href  <= h1;
         out_vsync <= v1;
         out_de    <= d1;
         for (int unsigned i = 0; i < 3; i++) begin
            prod[i] <= in_href ? P_W'(pix[i]) * P_W'(gsel[i]) : '0;
            opx[i]  <= sat_px(prod[i]);
         end
      end
   end

   assign out_r = opx[0];
   assign out_g = opx[1];
   assign out_b = opx[2];

endmodule
